// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register and single-outstanding instruction fetch sequencer
//            with exception trap and fetch-timeout fault handling.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [11:0] TRAP_PC     = 12'h004,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] new_PC,
    output logic [11:0] PC_plus_1,
    output logic [11:0] pc,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_taken,
    input  logic        stall,
    input  logic        excep_req,
    output logic [11:0] epc,
    output logic        fetch_fault
);

    // Counter value in the last request cycle before a timeout is declared.
    localparam logic [7:0] c_ack_last = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_instr_valid, w_valid_nxt;
    logic [11:0] r_epc, w_epc_nxt;
    logic        r_fault, w_fault_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    // Low in the reset window so no request is issued until the first clock edge.
    logic        r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_epc         <= 12'h000;
            r_fault       <= 1'b0;
            r_cnt         <= 8'h00;
            r_run         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_valid_nxt;
            r_epc         <= w_epc_nxt;
            r_fault       <= w_fault_nxt;
            r_cnt         <= w_cnt_nxt;
            r_run         <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_instr_valid;
        w_epc_nxt   = r_epc;
        w_fault_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (r_run) begin
            case (r_state)
                FETCH: begin
                    // Exception beats a same-cycle ack; the returned word is dropped.
                    if (excep_req) begin
                        w_epc_nxt   = r_pc;
                        w_valid_nxt = 1'b0;
                        w_cnt_nxt   = 8'h00;
                        w_state_nxt = TRAP;
                    end else if (imem_ack) begin
                        w_instr_nxt = imem_rdata;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = 8'h00;
                        w_state_nxt = HOLD;
                    end else if (r_cnt == c_ack_last) begin
                        w_fault_nxt = 1'b1;
                        w_epc_nxt   = r_pc;
                        w_cnt_nxt   = 8'h00;
                        w_state_nxt = TRAP;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (excep_req) begin
                        w_epc_nxt   = r_pc;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = TRAP;
                    end else if (instr_taken && !stall) begin
                        w_pc_nxt    = new_PC;
                        w_valid_nxt = 1'b0;
                        w_cnt_nxt   = 8'h00;
                        w_state_nxt = FETCH;
                    end
                end
                TRAP: begin
                    w_pc_nxt    = TRAP_PC;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = 8'h00;
                    w_state_nxt = FETCH;
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign PC_plus_1   = r_pc + 12'd1;
    assign imem_req    = r_run && (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign epc         = r_epc;
    assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed self-checking bench for pc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [11:0] new_PC;
    logic [11:0] PC_plus_1;
    logic [11:0] pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_taken;
    logic        stall;
    logic        excep_req;
    logic [11:0] epc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(
        .RESET_PC    (12'h000),
        .TRAP_PC     (12'h004),
        .ACK_TIMEOUT (15)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_PC      (new_PC),
        .PC_plus_1   (PC_plus_1),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_taken (instr_taken),
        .stall       (stall),
        .excep_req   (excep_req),
        .epc         (epc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ack the current fetch with the given word, then release ack.
    task automatic ack_with(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
    endtask

    // Retire the held instruction towards target.
    task automatic retire(input logic [11:0] target);
        new_PC      = target;
        instr_taken = 1'b1;
        tick();
        instr_taken = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        new_PC      = 12'h000;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_taken = 1'b0;
        stall       = 1'b0;
        excep_req   = 1'b0;

        tick();
        tick();
        chk("rst_pc",    {20'h0, pc}, 32'h000);
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_epc",   {20'h0, epc}, 32'h000);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("rst_pcp1",  {20'h0, PC_plus_1}, 32'h001);

        // Reset release, ack after two request cycles.
        rst_n = 1'b1;
        tick();
        chk("first_req",  {31'h0, imem_req}, 32'h1);
        chk("first_addr", {20'h0, imem_addr}, 32'h000);
        tick();
        ack_with(32'h1234_5678);
        chk("cap_instr", instr, 32'h1234_5678);
        chk("cap_valid", {31'h0, instr_valid}, 32'h1);
        chk("cap_req",   {31'h0, imem_req}, 32'h0);
        chk("cap_pcp1",  {20'h0, PC_plus_1}, 32'h001);

        // Retire blocked by stall for three cycles.
        new_PC      = 12'h0A0;
        instr_taken = 1'b1;
        stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    {20'h0, pc}, 32'h000);
            chk("stall_valid", {31'h0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        instr_taken = 1'b0;
        chk("ret_pc",    {20'h0, pc}, 32'h0A0);
        chk("ret_addr",  {20'h0, imem_addr}, 32'h0A0);
        chk("ret_req",   {31'h0, imem_req}, 32'h1);
        chk("ret_valid", {31'h0, instr_valid}, 32'h0);

        // Asynchronous reset while holding at 0A0.
        ack_with(32'hDEAD_BEEF);
        chk("hold0a0_valid", {31'h0, instr_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    {20'h0, pc}, 32'h000);
        chk("arst_instr", instr, 32'h0);
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_req",   {31'h0, imem_req}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerun_req",  {31'h0, imem_req}, 32'h1);
        chk("rerun_addr", {20'h0, imem_addr}, 32'h000);

        // PC wrap at FFF.
        ack_with(32'h0000_0011);
        retire(12'hFFF);
        chk("fff_pc",   {20'h0, pc}, 32'hFFF);
        chk("fff_pcp1", {20'h0, PC_plus_1}, 32'h000);
        ack_with(32'h0000_0022);
        retire(PC_plus_1);
        chk("wrap_addr", {20'h0, imem_addr}, 32'h000);
        chk("wrap_req",  {31'h0, imem_req}, 32'h1);

        // Exception collides with ack at 050; exception in TRAP is ignored.
        ack_with(32'h0000_0033);
        retire(12'h050);
        excep_req  = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        tick();
        imem_ack = 1'b0;
        chk("exc_instr", instr, 32'h0000_0033);
        chk("exc_epc",   {20'h0, epc}, 32'h050);
        chk("exc_req",   {31'h0, imem_req}, 32'h0);
        chk("exc_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        excep_req = 1'b0;
        chk("trap_epc",  {20'h0, epc}, 32'h050);
        chk("trap_pc",   {20'h0, pc}, 32'h004);
        chk("trap_req",  {31'h0, imem_req}, 32'h1);

        // Timeout at 030: fifteen request cycles without ack.
        ack_with(32'h0000_0044);
        retire(12'h030);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("wait_fault", {31'h0, fetch_fault}, 32'h0);
            chk("wait_req",   {31'h0, imem_req}, 32'h1);
        end
        tick();
        chk("to_fault", {31'h0, fetch_fault}, 32'h1);
        chk("to_epc",   {20'h0, epc}, 32'h030);
        chk("to_req",   {31'h0, imem_req}, 32'h0);
        tick();
        chk("to_fault_end", {31'h0, fetch_fault}, 32'h0);
        chk("to_refetch",   {20'h0, imem_addr}, 32'h004);
        chk("to_req2",      {31'h0, imem_req}, 32'h1);

        // Ack arriving in the last allowed cycle wins over the timeout.
        for (int i = 0; i < 14; i++) tick();
        ack_with(32'hCAFE_F00D);
        chk("late_fault", {31'h0, fetch_fault}, 32'h0);
        chk("late_instr", instr, 32'hCAFE_F00D);
        chk("late_valid", {31'h0, instr_valid}, 32'h1);
        chk("late_epc",   {20'h0, epc}, 32'h030);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter TRAP_PC, default 12'h004, meaning the PC loaded on exception or fetch timeout.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum wait cycles for imem_ack before a fetch fault (range 1..255).
REQ-004 SHALL have one clock and an asynchronous active-low reset, as the ports clk and rst_n below.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 new_PC  input  12  next-PC value from the PC select logic, sampled only on an instruction retire.
REQ-008 PC_plus_1  output  12  current pc + 1, fed to the PC select logic.
REQ-009 pc  output  12  current PC register.
REQ-010 imem_req  output  1  instruction memory request, held high until ack or abort.
REQ-011 imem_addr  output  12  fetch address, equals pc while imem_req is high.
REQ-012 imem_ack  input  1  one-cycle memory completion strobe, valid only while imem_req is high.
REQ-013 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-014 instr  output  32  latched instruction.
REQ-015 instr_valid  output  1  instr holds the word fetched from pc.
REQ-016 instr_taken  input  1  decode consumes instr this cycle.
REQ-017 stall  input  1  blocks retire while high.
REQ-018 excep_req  input  1  synchronous exception request.
REQ-019 epc  output  12  PC of the instruction interrupted by the last exception or fault.
REQ-020 fetch_fault  output  1  one-cycle pulse on fetch timeout.

Function
REQ-021 SHALL implement the FSM states FETCH, HOLD and TRAP.
REQ-022 FETCH: imem_req=1, imem_addr=pc, wait counter increments each cycle; on imem_ack, instr<=imem_rdata, instr_valid<=1, counter<=0, go HOLD.
REQ-023 HOLD: imem_req=0, instr_valid=1; when instr_taken=1 and stall=0, pc<=new_PC, instr_valid<=0, go FETCH; otherwise hold everything.
REQ-024 instr_taken with stall=1 SHALL be ignored; no state, pc or instr change.
REQ-025 TRAP: one cycle, imem_req=0, instr_valid=0, pc<=TRAP_PC, go FETCH.
REQ-026 excep_req=1 in FETCH or HOLD SHALL: epc<=pc, clear instr_valid, drop imem_req next cycle, go TRAP; this has priority over imem_ack, instr_taken and timeout in the same cycle.
REQ-027 An imem_ack arriving in the same cycle as excep_req SHALL be discarded; instr is not updated.
REQ-028 excep_req in TRAP SHALL be ignored; epc is not overwritten.
REQ-029 Wait counter reaching ACK_TIMEOUT in FETCH without imem_ack SHALL: pulse fetch_fault for exactly one cycle, epc<=pc, go TRAP; imem_ack on the timeout cycle itself wins (normal capture, no fault).
REQ-030 PC_plus_1 SHALL be combinational pc+1 modulo 4096 (12'hFFF -> 12'h000).
REQ-031 new_PC SHALL be used unmodified; no alignment or range check.
REQ-032 Fetch latency: imem_req SHALL rise in the cycle after pc changes; instr_valid SHALL rise in the cycle after imem_ack.
REQ-033 The wait counter SHALL clear on every entry to FETCH.

Reset
REQ-034 rst_n low SHALL immediately force: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, epc=0, fetch_fault=0, counter=0; imem_req=0 while rst_n is low.
REQ-035 The first rising clk edge with rst_n high SHALL begin FETCH at RESET_PC (imem_req=1 in that cycle).
REQ-036 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack SHALL be ignored unless imem_req is high.

Verification
REQ-037 Reset release, ack after 2 cycles with rdata 32'h1234_5678 -> imem_addr=000, instr=32'h1234_5678, instr_valid=1, PC_plus_1=001.
REQ-038 HOLD, new_PC=12'h0A0, instr_taken=1 with stall=1 for 3 cycles, then stall=0 -> pc stays 000 for 3 cycles, then pc=0A0, next imem_addr=0A0.
REQ-039 pc=12'hFFF -> PC_plus_1=000; retire with new_PC=PC_plus_1 -> next fetch at 000.
REQ-040 FETCH at pc=050, excep_req and imem_ack in the same cycle -> instr unchanged, epc=050, TRAP one cycle, next fetch at 004.
REQ-041 No ack for ACK_TIMEOUT=15 cycles at pc=030 -> fetch_fault high exactly one cycle, epc=030, refetch at 004.
REQ-042 rst_n pulsed low during HOLD at pc=0A0 -> outputs at reset values asynchronously, fetch restarts at 000.
